// File: rtl/vec_load_sequencer_pkg.sv
// vec_load_sequencer_pkg: shared state, addressing-mode and element-width types
// for the vector load sequencer.
package vec_load_sequencer_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} v_ld_state_e;
    typedef enum logic [1:0] {UNIT = 2'b00, IDX_UO = 2'b01, STRIDED = 2'b10, IDX_O = 2'b11} v_mop_e;
    typedef enum logic [1:0] {E8 = 2'b00, E16 = 2'b01, E32 = 2'b10} v_sew_e;
    function automatic logic [2:0] sew_bytes(input v_sew_e s);
        return {s == E32, s == E16, s == E8};
    endfunction
endpackage

// File: rtl/vec_ld_addr_gen.sv
// vec_ld_addr_gen: element address accumulator with unit-stride increment;
// the stride register and stride selection exist only with VEC_LD_STRIDED_EN.
module vec_ld_addr_gen
    import vec_load_sequencer_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            advance,
    input  logic [XLEN-1:0] base,
    input  v_sew_e          sew,
`ifdef VEC_LD_STRIDED_EN
    input  logic [XLEN-1:0] stride,
    input  logic            strided,
`endif
    output logic [XLEN-1:0] addr
);
    logic [XLEN-1:0] incr;
`ifdef VEC_LD_STRIDED_EN
    logic [XLEN-1:0] stride_q;
    logic            strided_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stride_q  <= '0;
            strided_q <= 1'b0;
        end else if (load) begin
            stride_q  <= stride;
            strided_q <= strided;
        end
    end
    assign incr = strided_q ? stride_q : XLEN'(sew_bytes(sew));
`else
    assign incr = XLEN'(sew_bytes(sew));
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) addr <= '0;
        else addr <= load ? base : advance ? addr + incr : addr;
    end
endmodule

// File: rtl/vec_load_sequencer.sv
// vec_load_sequencer: turns one vector load into single-element memory requests
// and VRF writes; strided mode is built only with VEC_LD_STRIDED_EN.
module vec_load_sequencer
    import vec_load_sequencer_pkg::*;
#(
    parameter  int XLEN  = 32,
    parameter  int VLMAX = 16,
    localparam int IDXW  = $clog2(VLMAX)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ld_start,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [1:0]      mop,
    input  logic [XLEN-1:0] vl,
    input  logic [2:0]      sew,
    input  logic [4:0]      vd_addr,
    output logic            ld_busy,
    output logic            ld_done,
    output logic            ld_err,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    output logic [1:0]      mem_req_size,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic            vrf_wr_en,
    output logic [4:0]      vrf_wr_addr,
    output logic [IDXW-1:0] vrf_wr_idx,
    output logic [XLEN-1:0] vrf_wr_data
);
    localparam int CNTW = IDXW + 1;
    v_ld_state_e     state, state_nxt;
    v_sew_e          sew_q;
    logic [4:0]      vd_q;
    logic [CNTW-1:0] elem_cnt, cnt_in;
    logic [IDXW-1:0] idx;
    logic            err_q, err_in, start, accept, rsp, last;
    logic [XLEN-1:0] rsp_elem;

    assign start  = state == IDLE && ld_start;
    assign accept = state == REQ && mem_req_ready;
    assign rsp    = state == WAIT_RSP && mem_rsp_valid;
    assign last   = {1'b0, idx} == elem_cnt - CNTW'(1);
    assign cnt_in = vl > XLEN'(VLMAX) ? CNTW'(VLMAX) : vl[CNTW-1:0];
    assign rsp_elem = sew_q == E8 ? XLEN'(mem_rsp_data[7:0]) :
                      sew_q == E16 ? XLEN'(mem_rsp_data[15:0]) : mem_rsp_data;
    assign mem_req_size = sew_q;
`ifdef VEC_LD_STRIDED_EN
    assign err_in = sew > 3'b010 || mop[0];
`else
    logic unused_stride;
    assign unused_stride = ^rs2_data;
    assign err_in = sew > 3'b010 || mop != UNIT;
`endif

    vec_ld_addr_gen #(.XLEN(XLEN)) u_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .load    (start),
        .advance (accept),
        .base    (rs1_data),
        .sew     (sew_q),
`ifdef VEC_LD_STRIDED_EN
        .stride  (rs2_data),
        .strided (mop == STRIDED),
`endif
        .addr    (mem_req_addr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     state_nxt = !ld_start ? IDLE : (err_in || cnt_in == '0) ? DONE : REQ;
            REQ:      state_nxt = mem_req_ready ? WAIT_RSP : REQ;
            WAIT_RSP: state_nxt = !mem_rsp_valid ? WAIT_RSP : last ? DONE : REQ;
            DONE:     state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ld_busy       = state != IDLE;
        ld_done       = state == DONE;
        ld_err        = state == DONE && err_q;
        mem_req_valid = state == REQ;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sew_q       <= E8;
            vd_q        <= '0;
            elem_cnt    <= '0;
            idx         <= '0;
            err_q       <= 1'b0;
            vrf_wr_en   <= 1'b0;
            vrf_wr_addr <= '0;
            vrf_wr_idx  <= '0;
            vrf_wr_data <= '0;
        end else begin
            vrf_wr_en <= rsp;
            if (start) begin
                sew_q    <= v_sew_e'(sew[1:0]);
                vd_q     <= vd_addr;
                elem_cnt <= cnt_in;
                idx      <= '0;
                err_q    <= err_in;
            end
            if (rsp) begin
                vrf_wr_addr <= vd_q;
                vrf_wr_idx  <= idx;
                vrf_wr_data <= rsp_elem;
                idx         <= idx + IDXW'(1);
            end
        end
    end
endmodule

// File: tb/tb_vec_load_sequencer.sv
// tb_vec_load_sequencer: table-driven zero-wait load vectors plus hand-written
// backpressure, stray-response and mid-operation reset sequences.
module tb_vec_load_sequencer;
    logic        clk = 1'b0;
    logic        reset, ld_start, mem_req_ready, mem_rsp_valid;
    logic [31:0] rs1_data, rs2_data, vl, mem_rsp_data;
    logic [1:0]  mop;
    logic [2:0]  sew;
    logic [4:0]  vd_addr;
    logic        ld_busy, ld_done, ld_err, mem_req_valid, vrf_wr_en;
    logic [31:0] mem_req_addr, vrf_wr_data;
    logic [1:0]  mem_req_size;
    logic [4:0]  vrf_wr_addr;
    logic [3:0]  vrf_wr_idx;
    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] base, stride, vl, rsp;
        logic [1:0]  mop;
        logic [2:0]  sew;
        logic [4:0]  vd;
        logic        err;
        int          n;
        logic [31:0] incr, mask;
    } vec_t;
    vec_t tv[10];

    vec_load_sequencer dut (
        .clk(clk), .reset(reset), .ld_start(ld_start), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .mop(mop), .vl(vl), .sew(sew), .vd_addr(vd_addr), .ld_busy(ld_busy), .ld_done(ld_done),
        .ld_err(ld_err), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_size(mem_req_size), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data), .vrf_wr_en(vrf_wr_en), .vrf_wr_addr(vrf_wr_addr),
        .vrf_wr_idx(vrf_wr_idx), .vrf_wr_data(vrf_wr_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " addr"}, mem_req_addr, 32'h0);
        chk({tag, " wdata"}, vrf_wr_data, 32'h0);
        chk({tag, " ctl"}, 32'({ld_busy, ld_done, ld_err, mem_req_valid, mem_req_size,
                                vrf_wr_en, vrf_wr_addr, vrf_wr_idx}), 32'h0);
    endtask

    task automatic drive_start(input logic [31:0] base, input logic [31:0] stride, input logic [1:0] m,
                               input logic [31:0] len, input logic [2:0] s, input logic [4:0] vd);
        ld_start = 1'b1; rs1_data = base; rs2_data = stride; mop = m; vl = len; sew = s; vd_addr = vd;
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int done_c, kq, kw;
        logic pend;
        done_c = (v.err || v.n == 0) ? 1 : 2 * v.n + 1;
        kq = 0; kw = 0; pend = 1'b0;
        @(posedge clk); #1;
        drive_start(v.base, v.stride, v.mop, v.vl, v.sew, v.vd);
        for (int c = 1; c <= done_c + 1; c++) begin
            @(posedge clk); #1;
            ld_start = 1'b0;
            mem_rsp_valid = pend;
            mem_rsp_data = pend ? v.rsp + 32'(kw) : 32'h0;
            @(negedge clk);
            chk($sformatf("v%0d c%0d busy", id, c), 32'(ld_busy), 32'(c <= done_c));
            chk($sformatf("v%0d c%0d done", id, c), 32'(ld_done), 32'(c == done_c));
            chk($sformatf("v%0d c%0d err", id, c), 32'(ld_err), 32'(c == done_c && v.err));
            chk($sformatf("v%0d c%0d req_valid", id, c), 32'(mem_req_valid),
                32'(c % 2 == 1 && (c - 1) / 2 < v.n));
            if (mem_req_valid) begin
                chk($sformatf("v%0d req%0d addr", id, kq), mem_req_addr, v.base + 32'(kq) * v.incr);
                chk($sformatf("v%0d req%0d size", id, kq), 32'(mem_req_size), 32'(v.sew[1:0]));
                kq++;
            end
            chk($sformatf("v%0d c%0d wr_en", id, c), 32'(vrf_wr_en),
                32'(c >= 3 && c % 2 == 1 && (c - 3) / 2 < v.n));
            if (vrf_wr_en) begin
                chk($sformatf("v%0d wr%0d idx", id, kw), 32'(vrf_wr_idx), 32'(kw));
                chk($sformatf("v%0d wr%0d vd", id, kw), 32'(vrf_wr_addr), 32'(v.vd));
                chk($sformatf("v%0d wr%0d data", id, kw), vrf_wr_data, (v.rsp + 32'(kw)) & v.mask);
                kw++;
            end
            pend = mem_req_valid;
        end
        mem_rsp_valid = 1'b0;
        chk($sformatf("v%0d write count", id), 32'(kw), 32'(v.n));
    endtask

    initial begin
        reset = 1'b1; ld_start = 1'b0; mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        rs1_data = '0; rs2_data = '0; mop = '0; vl = '0; sew = '0; vd_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_quiet("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        tv[0] = '{32'h1000, 32'h0, 32'd4, 32'h12345678, 2'b00, 3'b010, 5'd4, 1'b0, 4, 32'd4, 32'hFFFFFFFF};
        tv[1] = '{32'h2003, 32'h0, 32'd3, 32'hAABBCCDD, 2'b00, 3'b000, 5'd9, 1'b0, 3, 32'd1, 32'h000000FF};
        tv[2] = '{32'h3000, 32'h0, 32'd2, 32'h8765FFFE, 2'b00, 3'b001, 5'd31, 1'b0, 2, 32'd2, 32'h0000FFFF};
`ifdef VEC_LD_STRIDED_EN
        tv[3] = '{32'h4000, 32'h20, 32'd3, 32'hAABBCCDD, 2'b10, 3'b000, 5'd1, 1'b0, 3, 32'h20, 32'h000000FF};
`else
        tv[3] = '{32'h4000, 32'h20, 32'd3, 32'hAABBCCDD, 2'b10, 3'b000, 5'd1, 1'b1, 0, 32'h20, 32'h000000FF};
`endif
        tv[4] = '{32'h5000, 32'h0, 32'd0, 32'h0, 2'b00, 3'b010, 5'd2, 1'b0, 0, 32'd4, 32'hFFFFFFFF};
        tv[5] = '{32'h0100, 32'h0, 32'd100, 32'h01020300, 2'b00, 3'b010, 5'd5, 1'b0, 16, 32'd4, 32'hFFFFFFFF};
        tv[6] = '{32'hFFFFFFFC, 32'h0, 32'd2, 32'hCAFE0000, 2'b00, 3'b010, 5'd6, 1'b0, 2, 32'd4, 32'hFFFFFFFF};
        tv[7] = '{32'h6000, 32'h0, 32'd4, 32'h0, 2'b01, 3'b010, 5'd7, 1'b1, 0, 32'd4, 32'hFFFFFFFF};
        tv[8] = '{32'h7000, 32'h0, 32'd4, 32'h0, 2'b00, 3'b011, 5'd8, 1'b1, 0, 32'd4, 32'hFFFFFFFF};
        tv[9] = '{32'h8000, 32'h0, 32'd4, 32'h0, 2'b11, 3'b000, 5'd10, 1'b1, 0, 32'd1, 32'h000000FF};
        for (int i = 0; i < 10; i++) run_vec(i, tv[i]);

        // backpressure: request held for three cycles, second start pulse ignored
        @(posedge clk); #1;
        drive_start(32'h500, 32'h0, 2'b00, 32'd2, 3'b010, 5'd12);
        mem_req_ready = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            ld_start = (c == 2);
            rs1_data = (c == 2) ? 32'h9000 : 32'h500;
            @(negedge clk);
            chk($sformatf("bp c%0d valid", c), 32'(mem_req_valid), 32'h1);
            chk($sformatf("bp c%0d addr", c), mem_req_addr, 32'h500);
            chk($sformatf("bp c%0d size", c), 32'(mem_req_size), 32'h2);
        end
        @(posedge clk); #1;
        ld_start = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        chk("bp c4 addr", mem_req_addr, 32'h500);
        @(posedge clk); #1;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h11;
        @(negedge clk);
        chk("bp c5 valid", 32'(mem_req_valid), 32'h0);
        chk("bp c5 acc", mem_req_addr, 32'h504);
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("bp c6 wr_en", 32'(vrf_wr_en), 32'h1);
        chk("bp c6 data", vrf_wr_data, 32'h11);
        chk("bp c6 addr", mem_req_addr, 32'h504);
        @(posedge clk); #1;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h22;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("bp c8 done", 32'(ld_done), 32'h1);
        chk("bp c8 idx", 32'(vrf_wr_idx), 32'h1);
        chk("bp c8 data", vrf_wr_data, 32'h22);

        // stray responses in IDLE must not write
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            mem_rsp_valid = 1'b1; mem_rsp_data = 32'h99;
            @(negedge clk);
            chk($sformatf("stray c%0d wr_en", c), 32'(vrf_wr_en), 32'h0);
            chk($sformatf("stray c%0d busy", c), 32'(ld_busy), 32'h0);
        end
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;

        // reset while waiting for the first response
        drive_start(32'h600, 32'h0, 2'b00, 32'd4, 3'b010, 5'd3);
        @(posedge clk); #1;
        ld_start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst pre busy", 32'(ld_busy), 32'h1);
        @(posedge clk); #1;
        reset = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h55;
        @(negedge clk);
        chk_quiet("rst mid");
        @(posedge clk); #1;
        @(negedge clk);
        chk_quiet("rst hold");
        @(posedge clk); #1;
        reset = 1'b0; mem_rsp_valid = 1'b0;
        run_vec(100, tv[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
